mdio_phy_responder: RTL and testbench
=====================================

Name: mdio_phy_responder

Overview:
- Clause-22 MDIO management responder (PHY side), the far end of the TSE MAC MDIO master (mdc / mdio_in / mdio_out / mdio_oen).
- Decodes read/write frames, holds a 32-entry x 16-bit PHY register model and drives read data back.
- Stands in for the external PHY management port in board-level loopback and in simulation; exports the control register and write events to fabric logic.

Parameters:
PHY_ADDR, 5'd1, PHYAD this responder answers to
PHY_ID1, 16'h0022, read-only value of reg 2
PHY_ID2, 16'h1622, read-only value of reg 3
STATUS_CAP, 16'h7949, reg 1 bits [15:3]; bits [2:0] generated internally
CTRL_DEFAULT, 16'h1140, reset/soft-reset value of reg 0
PREAMBLE_MIN, 32, consecutive ones required before ST; legal 1..32

Ports:
clk  in  1  system clock, 50 MHz, at least 10x MDC
reset_n  in  1  asynchronous active-low reset
mdc  in  1  management clock from master, asynchronous, up to 2.5 MHz
mdio_in  in  1  MDIO line as seen by responder, asynchronous
mdio_out  out  1  MDIO drive value
mdio_oen  out  1  1 = responder drives MDIO, 0 = released
link_up  in  1  live link indication, asynchronous
ctrl_reg  out  16  current reg 0 contents
wr_strobe  out  1  1-clk pulse per accepted write to a RW register
wr_addr  out  5  register address of last accepted write
wr_data  out  16  data of last accepted write
frame_err  out  1  1-clk pulse on malformed frame

Behaviour:
- Reset: mdio_out=0, mdio_oen=0, wr_strobe=0, frame_err=0, wr_addr=0, wr_data=0, ctrl_reg=CTRL_DEFAULT, regs 4..31=0, link latch=0, FSM=IDLE, preamble count=0.
- Synchronisation: mdc, mdio_in and link_up each pass through a 2-FF synchroniser. MDC rising edge = synced mdc high with previous synced value low. All bit sampling occurs on that detect cycle only.
- Drive updates are registered 1 clk after edge detect. This gives ~60 ns clock-to-out from MDC rise, within the 300 ns limit.
- Bit order: MSB first throughout.
- FSM states and transitions:
  - IDLE: each sampled 1 increments preamble count (saturates at 32). On a sampled 0: if count >= PREAMBLE_MIN, go to ST2 (this 0 is ST bit 1); otherwise clear count and stay.
  - ST2: 1 -> OP; 0 -> frame_err, IDLE.
  - OP (2 bits): 10 = read, 01 = write. 00/11 -> frame_err, IDLE.
  - PHYAD (5 bits): addressed = (PHYAD == PHY_ADDR). If not addressed, the frame is tracked to its end with no drive and no write.
  - REGAD (5 bits): on the last REGAD bit, read data is snapshotted from the register model.
  - TA (2 bits):
    - Read, addressed: after the TA1 sample edge, mdio_oen=1 and mdio_out=0.
    - Write: TA must sample 10; otherwise frame_err, IDLE.
  - DATA (16 bits):
    - Read: after the edge that samples TA2, drive bit 15; after each following edge, drive the next bit. After the edge that samples bit 0, set mdio_oen=0 and mdio_out=0, go to IDLE.
    - Write: shift in 16 bits. On the 16th, if addressed, commit the write, then go to IDLE.
- Return to IDLE from any state clears the preamble count, so every frame needs a fresh preamble.
- Register map:
  - reg 0: RW. Writing bit 15=1 is a soft reset: on the next clk, reg 0 = CTRL_DEFAULT, regs 4..31 = 0, link latch = 0. Bit 15 therefore always reads 0.
  - reg 1: RO = {STATUS_CAP[15:3], link_latch, 2'b00}.
  - reg 2: RO = PHY_ID1.
  - reg 3: RO = PHY_ID2.
  - regs 4..31: RW, reset 0.
- Write side effects: writes to RO registers are ignored, with no wr_strobe. An accepted write pulses wr_strobe for 1 clk in the commit cycle; wr_addr and wr_data update in the same cycle.
- Link latch (latching-low):
  - Cleared every clk while synced link_up=0.
  - On completion of an addressed read of reg 1 (release edge), loaded with synced link_up.
  - If link_up falls on that same clk, the clear wins.
- No MDC timeout: a stalled MDC holds state indefinitely. reset_n low mid-frame releases mdio_oen immediately (async).

Test Plan:
- Reset assert/release -> mdio_oen=0, mdio_out=0, ctrl_reg=16'h1140, frame_err=0.
- Frame: 32 ones, write PHYAD 1 reg 4 = 16'hA5A5, then read reg 4 -> exactly one wr_strobe with wr_addr=4, wr_data=16'hA5A5. Read phase: TA2=0, data 16'hA5A5, mdio_oen high for exactly 17 MDC periods.
- Read reg 2 / reg 3 -> 16'h0022 / 16'h1622. Write 16'hFFFF to reg 2 -> no wr_strobe, readback still 16'h0022.
- Write to PHYAD 5 reg 4 -> mdio_oen never asserts, no wr_strobe. Read to PHYAD 5 -> mdio_oen never asserts.
- Framing errors:
  - 31-one preamble then valid frame -> ignored, no response.
  - OP=11 after a valid preamble -> frame_err single pulse, no drive.
  - Write with TA=11 -> frame_err, no commit.
- Link latch and soft reset:
  - link_up=1, pulse link_up low for 5 clk, then read reg 1 -> 16'h7948 (bit 2=0).
  - Second read of reg 1 -> 16'h794C.
  - Write reg 0 = 16'h8000 -> ctrl_reg=16'h1140 and reg 4 reads 0.

Source files
------------

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO management responder (PHY side) with a 32 x 16-bit register model.
// MDC, MDIO and link_up are synchronised into clk; all bit handling happens on the detected MDC rise.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1622,
    parameter logic [15:0] STATUS_CAP   = 16'h7949,
    parameter logic [15:0] CTRL_DEFAULT = 16'h1140,
    parameter int          PREAMBLE_MIN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        link_up,
    output logic [15:0] ctrl_reg,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);

    // state   | meaning
    // S_IDLE  | counting preamble ones; a 0 after enough ones is ST bit 1
    // S_ST2   | expecting ST bit 2 (1)
    // S_OP    | shifting 2 opcode bits (10 read, 01 write)
    // S_PHYAD | shifting 5 PHY address bits
    // S_REGAD | shifting 5 register address bits, snapshot read data on the last
    // S_TA    | turnaround: drive 0 for addressed reads, check 10 for writes
    // S_DATA  | 16 data bits: shift out (read) or shift in and commit (write)
    typedef enum logic [2:0] {
        S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  mdc_sync_q, mdio_sync_q, link_sync_q;
    logic        mdc_prev_q;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [14:0] in_sh_q, in_sh_d;
    logic [15:0] rd_sh_q, rd_sh_d;
    logic        is_read_q, is_read_d;
    logic        addressed_q, addressed_d;
    logic [4:0]  regad_q, regad_d;
    logic        mdio_out_q, mdio_out_d;
    logic        mdio_oen_q, mdio_oen_d;
    logic        frame_err_q, frame_err_d;
    logic        wr_commit, link_load;
    logic        wr_strobe_q;
    logic [4:0]  wr_addr_q;
    logic [15:0] wr_data_q;
    logic [15:0] ctrl_q;
    logic [15:0] gp_q [4:31];
    logic        link_latch_q, soft_rst_q;
    logic        mdc_rise, mdio_bit, link_s;
    logic [4:0]  addr5;
    logic [15:0] wdata16, rd_mux;

    assign mdc_rise = mdc_sync_q[1] & ~mdc_prev_q;
    assign mdio_bit = mdio_sync_q[1];
    assign link_s   = link_sync_q[1];
    assign addr5    = {in_sh_q[3:0], mdio_bit};
    assign wdata16  = {in_sh_q, mdio_bit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
            link_sync_q <= '0;
            mdc_prev_q  <= 1'b0;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[0], mdc};
            mdio_sync_q <= {mdio_sync_q[0], mdio_in};
            link_sync_q <= {link_sync_q[0], link_up};
            mdc_prev_q  <= mdc_sync_q[1];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr5)
            5'd0:    rd_mux = ctrl_q;
            5'd1:    rd_mux = {STATUS_CAP[15:3], link_latch_q, 2'b00};
            5'd2:    rd_mux = PHY_ID1;
            5'd3:    rd_mux = PHY_ID2;
            default: rd_mux = gp_q[addr5];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            in_sh_q     <= '0;
            rd_sh_q     <= '0;
            is_read_q   <= 1'b0;
            addressed_q <= 1'b0;
            regad_q     <= '0;
            mdio_out_q  <= 1'b0;
            mdio_oen_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            in_sh_q     <= in_sh_d;
            rd_sh_q     <= rd_sh_d;
            is_read_q   <= is_read_d;
            addressed_q <= addressed_d;
            regad_q     <= regad_d;
            mdio_out_q  <= mdio_out_d;
            mdio_oen_q  <= mdio_oen_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        in_sh_d     = in_sh_q;
        rd_sh_d     = rd_sh_q;
        is_read_d   = is_read_q;
        addressed_d = addressed_q;
        regad_d     = regad_q;
        mdio_out_d  = mdio_out_q;
        mdio_oen_d  = mdio_oen_q;
        frame_err_d = 1'b0;
        wr_commit   = 1'b0;
        link_load   = 1'b0;
        if (mdc_rise) begin
            in_sh_d   = {in_sh_q[13:0], mdio_bit};
            bit_cnt_d = bit_cnt_q + 4'd1;
            case (state_q)
                S_IDLE: begin
                    bit_cnt_d = '0;
                    if (mdio_bit) begin
                        if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else begin
                        pre_cnt_d = '0;
                        if (pre_cnt_q >= 6'(PREAMBLE_MIN)) state_d = S_ST2;
                    end
                end
                S_ST2: begin
                    bit_cnt_d = '0;
                    if (mdio_bit) begin
                        state_d = S_OP;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_OP: begin
                    if (bit_cnt_q == 4'd1) begin
                        bit_cnt_d = '0;
                        case ({in_sh_q[0], mdio_bit})
                            2'b10: begin is_read_d = 1'b1; state_d = S_PHYAD; end
                            2'b01: begin is_read_d = 1'b0; state_d = S_PHYAD; end
                            default: begin frame_err_d = 1'b1; state_d = S_IDLE; end
                        endcase
                    end
                end
                S_PHYAD: begin
                    if (bit_cnt_q == 4'd4) begin
                        bit_cnt_d   = '0;
                        addressed_d = (addr5 == PHY_ADDR);
                        state_d     = S_REGAD;
                    end
                end
                S_REGAD: begin
                    if (bit_cnt_q == 4'd4) begin
                        bit_cnt_d = '0;
                        regad_d   = addr5;
                        rd_sh_d   = rd_mux;
                        state_d   = S_TA;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == 4'd0) begin
                        if (is_read_q && addressed_q) begin
                            mdio_oen_d = 1'b1;
                            mdio_out_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = '0;
                        if (is_read_q) begin
                            if (addressed_q) begin
                                mdio_out_d = rd_sh_q[15];
                                rd_sh_d    = {rd_sh_q[14:0], 1'b0};
                            end
                            state_d = S_DATA;
                        end else if ({in_sh_q[0], mdio_bit} == 2'b10) begin
                            state_d = S_DATA;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        if (is_read_q) begin
                            mdio_oen_d = 1'b0;
                            mdio_out_d = 1'b0;
                            link_load  = addressed_q && (regad_q == 5'd1);
                        end else begin
                            // regs 1..3 are read-only; writes to them vanish silently
                            wr_commit = addressed_q && ((regad_q == 5'd0) || (regad_q >= 5'd4));
                        end
                    end else if (is_read_q && addressed_q) begin
                        mdio_out_d = rd_sh_q[15];
                        rd_sh_d    = {rd_sh_q[14:0], 1'b0};
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q       <= CTRL_DEFAULT;
            gp_q         <= '{default: '0};
            link_latch_q <= 1'b0;
            soft_rst_q   <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            wr_strobe_q <= wr_commit;
            soft_rst_q  <= wr_commit && (regad_q == 5'd0) && wdata16[15];
            if (wr_commit) begin
                wr_addr_q <= regad_q;
                wr_data_q <= wdata16;
                if (regad_q == 5'd0) ctrl_q <= {1'b0, wdata16[14:0]};
                else                 gp_q[regad_q] <= wdata16;
            end
            if (soft_rst_q) begin
                ctrl_q <= CTRL_DEFAULT;
                gp_q   <= '{default: '0};
            end
            // link low always wins over the load at the end of a reg 1 read
            if (!link_s || soft_rst_q) link_latch_q <= 1'b0;
            else if (link_load)        link_latch_q <= link_s;
        end
    end

    assign mdio_out  = mdio_out_q;
    assign mdio_oen  = mdio_oen_q;
    assign frame_err = frame_err_q;
    assign ctrl_reg  = ctrl_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: an MDIO master model drives frames; read data and
// write events are checked against expectations queued when each frame is issued.
module tb_mdio_phy_responder;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mdc = 1'b0;
    logic        link_up = 1'b1;
    logic        m_oe = 1'b1;
    logic        m_val = 1'b1;
    logic        mdio_in;
    logic        mdio_out, mdio_oen, wr_strobe, frame_err;
    logic [15:0] ctrl_reg, wr_data;
    logic [4:0]  wr_addr;

    int          n_tests = 0;
    int          n_fail = 0;
    int          ferr_cnt = 0;
    bit          oen_seen = 1'b0;
    logic [20:0] obs_wr_q[$];
    logic [20:0] exp_wr_q[$];
    logic [15:0] exp_rd_q[$];

    // open-drain bus with pull-up: responder, then master, else idle high
    assign mdio_in = mdio_oen ? mdio_out : (m_oe ? m_val : 1'b1);

    mdio_phy_responder dut (
        .clk(clk), .reset_n(reset_n), .mdc(mdc), .mdio_in(mdio_in),
        .mdio_out(mdio_out), .mdio_oen(mdio_oen), .link_up(link_up),
        .ctrl_reg(ctrl_reg), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (mdio_oen) oen_seen = 1'b1;
        if (wr_strobe) obs_wr_q.push_back({wr_addr, wr_data});
    end

    initial begin
        #1500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic mdc_bit(input logic oe, input logic val, output logic s_oen, output logic s_out);
        m_oe  = oe;
        m_val = val;
        repeat (HALF) @(negedge clk);
        s_oen = mdio_oen;
        s_out = mdio_out;
        mdc = 1'b1;
        repeat (HALF) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic mdio_frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                              input bit rd, output logic [15:0] rdata, output logic ta2,
                              output int oen_hi);
        logic so, sv;
        logic [13:0] hdr;
        oen_hi = 0;
        rdata  = '0;
        ta2    = 1'b1;
        mdc_bit(1'b1, 1'b0, so, sv);
        for (int i = 0; i < npre; i++) mdc_bit(1'b1, 1'b1, so, sv);
        hdr = {2'b01, op, phy, ra};
        for (int i = 13; i >= 0; i--) mdc_bit(1'b1, hdr[i], so, sv);
        if (rd) begin
            mdc_bit(1'b0, 1'b1, so, sv);
            if (so) oen_hi++;
            mdc_bit(1'b0, 1'b1, so, sv);
            ta2 = sv;
            if (so) oen_hi++;
            for (int i = 15; i >= 0; i--) begin
                mdc_bit(1'b0, 1'b1, so, sv);
                rdata[i] = sv;
                if (so) oen_hi++;
            end
        end else begin
            mdc_bit(1'b1, ta[1], so, sv);
            mdc_bit(1'b1, ta[0], so, sv);
            for (int i = 15; i >= 0; i--) mdc_bit(1'b1, wd[i], so, sv);
        end
        for (int i = 0; i < 2; i++) begin
            mdc_bit(1'b0, 1'b1, so, sv);
            if (so) oen_hi++;
        end
    endtask

    task automatic test_reset();
        logic [40:0] got;
        repeat (3) @(negedge clk);
        got = {mdio_oen, mdio_out, frame_err, wr_strobe, wr_addr, wr_data, ctrl_reg};
        n_tests++;
        if (got !== {4'b0000, 5'd0, 16'h0000, 16'h1140}) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected %h", got, {4'b0000, 5'd0, 16'h0000, 16'h1140});
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        got = {mdio_oen, mdio_out, frame_err, wr_strobe, wr_addr, wr_data, ctrl_reg};
        n_tests++;
        if (got !== {4'b0000, 5'd0, 16'h0000, 16'h1140}) begin
            n_fail++;
            $display("FAIL reset_released: got %h expected %h", got, {4'b0000, 5'd0, 16'h0000, 16'h1140});
        end
    endtask

    task automatic test_write_read();
        logic [15:0] rd, ex;
        logic t2;
        int oh;
        logic [20:0] e, o;
        ferr_cnt = 0;
        obs_wr_q.delete();
        exp_wr_q.push_back({5'd4, 16'hA5A5});
        mdio_frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'hA5A5, 1'b0, rd, t2, oh);
        n_tests++;
        if (obs_wr_q.size() != 1) begin
            n_fail++;
            $display("FAIL wr_strobe_count: got %0d expected 1", obs_wr_q.size());
        end
        while (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            o = (obs_wr_q.size() != 0) ? obs_wr_q.pop_front() : 21'h1FFFFF;
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wr_event: got %h expected %h", o, e);
            end
        end
        exp_rd_q.push_back(16'hA5A5);
        mdio_frame(32, 2'b10, 5'd1, 5'd4, 2'b00, 16'h0000, 1'b1, rd, t2, oh);
        ex = exp_rd_q.pop_front();
        n_tests++;
        if (rd !== ex) begin n_fail++; $display("FAIL read_reg4: got %h expected %h", rd, ex); end
        n_tests++;
        if (t2 !== 1'b0) begin n_fail++; $display("FAIL read_ta2: got %b expected 0", t2); end
        n_tests++;
        if (oh != 17) begin n_fail++; $display("FAIL read_oen_periods: got %0d expected 17", oh); end
        n_tests++;
        if (ferr_cnt != 0) begin n_fail++; $display("FAIL wr_rd_frame_err: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_id_regs();
        logic [4:0]  ra_tab [2] = '{5'd2, 5'd3};
        logic [15:0] ex_tab [2] = '{16'h0022, 16'h1622};
        logic [15:0] rd, ex;
        logic t2;
        int oh;
        for (int k = 0; k < 2; k++) begin
            exp_rd_q.push_back(ex_tab[k]);
            mdio_frame(32, 2'b10, 5'd1, ra_tab[k], 2'b00, 16'h0000, 1'b1, rd, t2, oh);
            ex = exp_rd_q.pop_front();
            n_tests++;
            if (rd !== ex) begin n_fail++; $display("FAIL read_id%0d: got %h expected %h", k + 1, rd, ex); end
        end
        obs_wr_q.delete();
        mdio_frame(32, 2'b01, 5'd1, 5'd2, 2'b10, 16'hFFFF, 1'b0, rd, t2, oh);
        n_tests++;
        if (obs_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL ro_write_strobe: got %0d strobes expected 0", obs_wr_q.size());
        end
        exp_rd_q.push_back(16'h0022);
        mdio_frame(32, 2'b10, 5'd1, 5'd2, 2'b00, 16'h0000, 1'b1, rd, t2, oh);
        ex = exp_rd_q.pop_front();
        n_tests++;
        if (rd !== ex) begin n_fail++; $display("FAIL ro_readback: got %h expected %h", rd, ex); end
    endtask

    task automatic test_unaddressed();
        logic [15:0] rd, ex;
        logic t2;
        int oh;
        obs_wr_q.delete();
        oen_seen = 1'b0;
        mdio_frame(32, 2'b01, 5'd5, 5'd4, 2'b10, 16'hFFFF, 1'b0, rd, t2, oh);
        n_tests++;
        if (oen_seen || obs_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL other_phy_write: got oen_seen=%0b strobes=%0d expected 0/0", oen_seen, obs_wr_q.size());
        end
        oen_seen = 1'b0;
        mdio_frame(32, 2'b10, 5'd5, 5'd4, 2'b00, 16'h0000, 1'b1, rd, t2, oh);
        n_tests++;
        if (oen_seen) begin n_fail++; $display("FAIL other_phy_read: got oen_seen=1 expected 0"); end
        exp_rd_q.push_back(16'hA5A5);
        mdio_frame(32, 2'b10, 5'd1, 5'd4, 2'b00, 16'h0000, 1'b1, rd, t2, oh);
        ex = exp_rd_q.pop_front();
        n_tests++;
        if (rd !== ex) begin n_fail++; $display("FAIL other_phy_reg4: got %h expected %h", rd, ex); end
    endtask

    task automatic test_frame_errors();
        logic [15:0] rd, ex;
        logic t2;
        int oh;
        oen_seen = 1'b0;
        ferr_cnt = 0;
        mdio_frame(31, 2'b10, 5'd1, 5'd2, 2'b00, 16'h0000, 1'b1, rd, t2, oh);
        n_tests++;
        if (oen_seen || ferr_cnt != 0) begin
            n_fail++;
            $display("FAIL short_preamble: got oen_seen=%0b frame_err=%0d expected 0/0", oen_seen, ferr_cnt);
        end
        oen_seen = 1'b0;
        ferr_cnt = 0;
        mdio_frame(32, 2'b11, 5'd1, 5'd2, 2'b10, 16'h0000, 1'b0, rd, t2, oh);
        n_tests++;
        if (ferr_cnt != 1 || oen_seen) begin
            n_fail++;
            $display("FAIL bad_opcode: got frame_err cycles=%0d oen_seen=%0b expected 1/0", ferr_cnt, oen_seen);
        end
        ferr_cnt = 0;
        obs_wr_q.delete();
        mdio_frame(32, 2'b01, 5'd1, 5'd4, 2'b11, 16'h0000, 1'b0, rd, t2, oh);
        n_tests++;
        if (ferr_cnt != 1 || obs_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL bad_write_ta: got frame_err cycles=%0d strobes=%0d expected 1/0", ferr_cnt, obs_wr_q.size());
        end
        exp_rd_q.push_back(16'hA5A5);
        mdio_frame(32, 2'b10, 5'd1, 5'd4, 2'b00, 16'h0000, 1'b1, rd, t2, oh);
        ex = exp_rd_q.pop_front();
        n_tests++;
        if (rd !== ex) begin n_fail++; $display("FAIL bad_ta_no_commit: got %h expected %h", rd, ex); end
    endtask

    task automatic test_link_latch();
        logic [15:0] ex_tab [4] = '{16'h7948, 16'h794C, 16'h7948, 16'h794C};
        logic [15:0] rd, ex;
        logic t2;
        int oh;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                link_up = 1'b0;
                repeat (5) @(negedge clk);
                link_up = 1'b1;
                repeat (4) @(negedge clk);
            end
            exp_rd_q.push_back(ex_tab[k]);
            mdio_frame(32, 2'b10, 5'd1, 5'd1, 2'b00, 16'h0000, 1'b1, rd, t2, oh);
            ex = exp_rd_q.pop_front();
            n_tests++;
            if (rd !== ex) begin n_fail++; $display("FAIL status_read%0d: got %h expected %h", k, rd, ex); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd, ex;
        logic t2;
        int oh;
        logic [20:0] e, o;
        obs_wr_q.delete();
        exp_wr_q.push_back({5'd31, 16'h1234});
        mdio_frame(32, 2'b01, 5'd1, 5'd31, 2'b10, 16'h1234, 1'b0, rd, t2, oh);
        exp_wr_q.push_back({5'd5, 16'h5A5A});
        mdio_frame(32, 2'b01, 5'd1, 5'd5, 2'b10, 16'h5A5A, 1'b0, rd, t2, oh);
        n_tests++;
        if (obs_wr_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_strobe_count: got %0d expected 2", obs_wr_q.size());
        end
        while (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            o = (obs_wr_q.size() != 0) ? obs_wr_q.pop_front() : 21'h1FFFFF;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_wr_event: got %h expected %h", o, e); end
        end
        exp_rd_q.push_back(16'h1234);
        mdio_frame(32, 2'b10, 5'd1, 5'd31, 2'b00, 16'h0000, 1'b1, rd, t2, oh);
        exp_rd_q.push_back(16'h5A5A);
        ex = exp_rd_q.pop_front();
        n_tests++;
        if (rd !== ex) begin n_fail++; $display("FAIL b2b_read31: got %h expected %h", rd, ex); end
        mdio_frame(32, 2'b10, 5'd1, 5'd5, 2'b00, 16'h0000, 1'b1, rd, t2, oh);
        ex = exp_rd_q.pop_front();
        n_tests++;
        if (rd !== ex) begin n_fail++; $display("FAIL b2b_read5: got %h expected %h", rd, ex); end
    endtask

    task automatic test_soft_reset();
        logic [4:0]  ra_tab [4] = '{5'd4, 5'd31, 5'd1, 5'd0};
        logic [15:0] ex_tab [4] = '{16'h0000, 16'h0000, 16'h7948, 16'h1140};
        logic [15:0] rd, ex;
        logic t2;
        int oh;
        logic [20:0] o;
        obs_wr_q.delete();
        mdio_frame(32, 2'b01, 5'd1, 5'd0, 2'b10, 16'h0100, 1'b0, rd, t2, oh);
        n_tests++;
        if (ctrl_reg !== 16'h0100) begin n_fail++; $display("FAIL ctrl_write: got %h expected 0100", ctrl_reg); end
        mdio_frame(32, 2'b01, 5'd1, 5'd0, 2'b10, 16'h8000, 1'b0, rd, t2, oh);
        n_tests++;
        if (ctrl_reg !== 16'h1140) begin n_fail++; $display("FAIL soft_reset_ctrl: got %h expected 1140", ctrl_reg); end
        o = (obs_wr_q.size() == 2) ? obs_wr_q[1] : 21'h1FFFFF;
        n_tests++;
        if (o !== {5'd0, 16'h8000}) begin
            n_fail++;
            $display("FAIL soft_reset_strobe: got %h (count %0d) expected %h", o, obs_wr_q.size(), {5'd0, 16'h8000});
        end
        for (int k = 0; k < 4; k++) begin
            exp_rd_q.push_back(ex_tab[k]);
            mdio_frame(32, 2'b10, 5'd1, ra_tab[k], 2'b00, 16'h0000, 1'b1, rd, t2, oh);
            ex = exp_rd_q.pop_front();
            n_tests++;
            if (rd !== ex) begin n_fail++; $display("FAIL soft_reset_read%0d: got %h expected %h", ra_tab[k], rd, ex); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_id_regs();
        test_unaddressed();
        test_frame_errors();
        test_link_latch();
        test_back_to_back();
        test_soft_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
